pattern_checker: RTL
====================

PATTERN_CHECKER -- requirements
Module: pattern_checker

Interface
REQ-001 SHALL have parameter NINPUTS, default 5, meaning the width of the DUT input vector.
REQ-002 SHALL have parameter NOUTPUTS, default 2, meaning the width of the DUT output vector.
REQ-003 SHALL have parameter DEPTH, default 4, meaning the pattern FIFO entry count (power of two, at least 2).
REQ-004 SHALL have parameter CAPTURE_DLY, default 4, meaning the number of clk cycles from a dut_pi update to the strobe (at least 1).
REQ-005 SHALL have parameter CNT_W, default 16, meaning the width of the pattern and fail counters.
REQ-006 SHALL have ports, one per line as below; there SHALL be one clock, and reset SHALL be asynchronous and active-high.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  single-cycle pulse that begins a run.
- stop_on_fail  in  1  ends the run at the first mismatch; sampled at start.
- pat_valid  in  1  pattern offered.
- pat_ready  out  1  FIFO can accept a pattern.
- pat_pi  in  NINPUTS  stimulus vector.
- pat_xpct  in  NOUTPUTS  expected response.
- pat_mask  in  NOUTPUTS  compare enable; 0 = X/don't-care.
- pat_last  in  1  final pattern of the run.
- dut_pi  out  NINPUTS  stimulus to the DUT.
- dut_po  in  NOUTPUTS  DUT response.
- busy  out  1  run in progress.
- done  out  1  run finished; held until the next start.
- pass  out  1  valid while done; 1 when fail_count = 0.
- fail_valid  out  1  one-cycle mismatch report.
- fail_index  out  CNT_W  index of the failing pattern.
- fail_bits  out  NOUTPUTS  mismatching bit positions.
- fail_count  out  CNT_W  failures this run; saturates at all-ones.
- pattern_count  out  CNT_W  patterns strobed this run; saturates at all-ones.

Function
REQ-007 SHALL accept a pattern on a clk edge where pat_valid and pat_ready are both 1; pat_ready SHALL equal not-full, so no push occurs when the FIFO is full.
REQ-008 SHALL have the states IDLE, FETCH, WAIT, STROBE and DONE.
REQ-009 In IDLE or DONE, a start pulse SHALL clear pattern_count and fail_count, latch stop_on_fail, clear done, and enter FETCH; start SHALL be ignored in the other states.
REQ-010 In FETCH with the FIFO non-empty, the block SHALL pop one entry, load dut_pi, xpct, mask and last on the same edge, load a delay counter with CAPTURE_DLY-1, and enter WAIT.
REQ-011 In FETCH with the FIFO empty, the block SHALL stall, and dut_pi SHALL hold its value.
REQ-012 WAIT SHALL decrement the delay counter and enter STROBE after it reaches 0, so that dut_po is sampled exactly CAPTURE_DLY cycles after dut_pi changes.
REQ-013 In STROBE, the block SHALL compute mismatch = (dut_po XOR xpct) AND mask and increment pattern_count.
REQ-014 If the mismatch in STROBE is non-zero, on the next cycle fail_valid SHALL be 1 for exactly one cycle, fail_index SHALL equal the pre-increment pattern_count, fail_bits SHALL equal the mismatch, and fail_count SHALL increment.
REQ-015 STROBE SHALL go to DONE if last is set, or if there is a mismatch and stop_on_fail is latched; otherwise it SHALL go to FETCH.
REQ-016 On a stop_on_fail exit, the FIFO SHALL be flushed; on a pat_last exit, remaining entries SHALL be kept for the next run.
REQ-017 A push into an empty FIFO SHALL become poppable one cycle later; there SHALL be no bypass path.
REQ-018 busy SHALL be 1 in FETCH, WAIT and STROBE; done and pass SHALL be registered outputs.
REQ-019 dut_pi, fail_index and fail_bits SHALL hold their last values until overwritten.

Reset
REQ-020 While rst is 1, the state SHALL be IDLE, the FIFO SHALL be empty, and every output SHALL be 0 except pat_ready, which SHALL be 1.
REQ-021 An assertion of rst during a run SHALL abort the run, with no fail_valid pulse produced.

Structure
REQ-022 The state encoding type and the minimum-parameter checks SHALL reside in the shared package pattern_checker_pkg.
REQ-023 The FIFO SHALL be the sub-module pattern_fifo, parametrised by DEPTH and a width of NINPUTS+2*NOUTPUTS+1, with a flush input.

Verification
REQ-024 Default parameters; push pi=11101, xpct=10, mask=11, last=1; dut_po=10; start -> after 4 wait cycles, STROBE occurs, pattern_count=1, done=1, pass=1, and no fail_valid pulse.
REQ-025 Push pi=01111, xpct=01, mask=11; dut_po=00 -> fail_valid pulse with fail_index=0 and fail_bits=01, and fail_count=1.
REQ-026 Push xpct=00, mask=10; dut_po=01 (masked bit differs) -> no fail; the same pattern with dut_po=10 -> fail_bits=10.
REQ-027 stop_on_fail=1; push 3 patterns with the 2nd failing -> done after pattern 2, pattern_count=2, FIFO empty, pat_ready=1.
REQ-028 Fill the FIFO with DEPTH entries and hold pat_valid -> pat_ready=0 and no overwrite; with an empty FIFO, start -> busy stays 1 in FETCH until a push, then the run proceeds.
REQ-029 Assert rst in WAIT -> all outputs 0 and FIFO empty; a following run behaves exactly as after power-up.

Source files
------------

// File: rtl/pattern_checker_pkg.sv
// Shared types and elaboration-time parameter checks for the pattern checker.
package pattern_checker_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    WAIT   = 3'd2,
    STROBE = 3'd3,
    DONE   = 3'd4
  } state_t;

  // DEPTH must be a power of two so the FIFO pointers can wrap naturally.
  function automatic bit params_ok(input int depth, input int capture_dly,
                                   input int ninputs, input int noutputs,
                                   input int cnt_w);
    return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (capture_dly >= 1) && (ninputs >= 1) && (noutputs >= 1) &&
           (cnt_w >= 1);
  endfunction

endpackage

// File: rtl/pattern_fifo.sv
// Pattern storage FIFO: registered storage only, so a push into an empty FIFO is poppable one cycle later.
module pattern_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  input  logic             flush,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  // A push coinciding with a flush is discarded along with the rest of the contents.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/pattern_checker.sv
// Applies queued stimulus patterns to a DUT, samples its response after a fixed delay,
// and reports masked mismatches with per-run pattern and failure counters.
module pattern_checker
  import pattern_checker_pkg::*;
#(
  parameter int NINPUTS     = 5,
  parameter int NOUTPUTS    = 2,
  parameter int DEPTH       = 4,
  parameter int CAPTURE_DLY = 4,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop_on_fail,
  input  logic                pat_valid,
  output logic                pat_ready,
  input  logic [NINPUTS-1:0]  pat_pi,
  input  logic [NOUTPUTS-1:0] pat_xpct,
  input  logic [NOUTPUTS-1:0] pat_mask,
  input  logic                pat_last,
  output logic [NINPUTS-1:0]  dut_pi,
  input  logic [NOUTPUTS-1:0] dut_po,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                fail_valid,
  output logic [CNT_W-1:0]    fail_index,
  output logic [NOUTPUTS-1:0] fail_bits,
  output logic [CNT_W-1:0]    fail_count,
  output logic [CNT_W-1:0]    pattern_count
);

  localparam int EW = NINPUTS + 2 * NOUTPUTS + 1;
  localparam int DW = (CAPTURE_DLY > 1) ? $clog2(CAPTURE_DLY) : 1;

  if (!params_ok(DEPTH, CAPTURE_DLY, NINPUTS, NOUTPUTS, CNT_W)) begin : g_param_check
    $error("pattern_checker: illegal parameter combination");
  end

  state_t              state;
  state_t              state_next;
  logic                fifo_pop;
  logic                fifo_flush;
  logic                fifo_full;
  logic                fifo_empty;
  logic [EW-1:0]       fifo_dout;
  logic [NOUTPUTS-1:0] xpct_q;
  logic [NOUTPUTS-1:0] mask_q;
  logic [NOUTPUTS-1:0] po_q;
  logic                last_q;
  logic                sof_q;
  logic [DW-1:0]       dly_cnt;
  logic [NOUTPUTS-1:0] mismatch;
  logic                has_fail;

  // Pattern handshake: a pattern transfers on a rising clk edge where pat_valid and
  // pat_ready are both 1; pat_ready is simply not-full and never depends on pat_valid.
  assign pat_ready = !fifo_full;
  assign busy      = (state == FETCH) || (state == WAIT) || (state == STROBE);
  // dut_po is captured on the WAIT exit edge, exactly CAPTURE_DLY cycles after dut_pi changed.
  assign mismatch  = (po_q ^ xpct_q) & mask_q;
  assign has_fail  = |mismatch;

  pattern_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (pat_valid && pat_ready),
    .din   ({pat_last, pat_mask, pat_xpct, pat_pi}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .flush (fifo_flush),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    case (state)
      IDLE, DONE: if (start) state_next = FETCH;
      FETCH: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: if (dly_cnt == '0) state_next = STROBE;
      STROBE: begin
        if (last_q || (has_fail && sof_q)) begin
          state_next = DONE;
          fifo_flush = has_fail && sof_q;
        end else begin
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dut_pi        <= '0;
      xpct_q        <= '0;
      mask_q        <= '0;
      last_q        <= 1'b0;
      po_q          <= '0;
      sof_q         <= 1'b0;
      dly_cnt       <= '0;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail_valid    <= 1'b0;
      fail_index    <= '0;
      fail_bits     <= '0;
      fail_count    <= '0;
      pattern_count <= '0;
    end else begin
      fail_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            pattern_count <= '0;
            fail_count    <= '0;
            sof_q         <= stop_on_fail;
            done          <= 1'b0;
            pass          <= 1'b0;
          end
        end
        FETCH: begin
          if (fifo_pop) begin
            {last_q, mask_q, xpct_q, dut_pi} <= fifo_dout;
            dly_cnt <= DW'(CAPTURE_DLY - 1);
          end
        end
        WAIT: begin
          if (dly_cnt == '0) po_q <= dut_po;
          else               dly_cnt <= dly_cnt - 1'b1;
        end
        STROBE: begin
          if (pattern_count != '1) pattern_count <= pattern_count + 1'b1;
          if (has_fail) begin
            fail_valid <= 1'b1;
            fail_index <= pattern_count;
            fail_bits  <= mismatch;
            if (fail_count != '1) fail_count <= fail_count + 1'b1;
          end
          if (state_next == DONE) begin
            done <= 1'b1;
            pass <= (fail_count == '0) && !has_fail;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
